// File: rtl/gray_counter_codec_if.sv
// Purpose: groups the counter controls/outputs and the Gray decode stream of gray_counter_codec.
// Latency: n/a (wiring only).
// Backpressure: none; the codec accepts every enabled step and every valid sample.
// Ports: master = stimulus side (drives en/up/load/load_bin/gray_in/gray_in_valid),
//        slave  = codec side (drives bin_out/gray_out/tc/dec_bin/dec_valid/step_err/err_sticky).
interface gray_counter_codec_if #(
  parameter int WIDTH = 8
);
  // counter path
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] gray_out;
  logic             tc;
  // decode path
  logic [WIDTH-1:0] gray_in;
  logic             gray_in_valid;
  logic [WIDTH-1:0] dec_bin;
  logic             dec_valid;
  logic             step_err;
  logic             err_sticky;

  modport master (
    output en, up, load, load_bin, gray_in, gray_in_valid,
    input  bin_out, gray_out, tc, dec_bin, dec_valid, step_err, err_sticky
  );

  modport slave (
    input  en, up, load, load_bin, gray_in, gray_in_valid,
    output bin_out, gray_out, tc, dec_bin, dec_valid, step_err, err_sticky
  );
endinterface

// File: rtl/gray_counter_codec.sv
// Purpose: registered Gray up/down counter with binary mirror, plus registered Gray-to-binary decode with step check.
// Latency: 1 cycle on both paths (inputs at edge N visible after edge N).
// Backpressure: none; every enabled step and every valid Gray sample is consumed in its cycle.
// Ports: clk, rst_n (synchronous, active-low); bus (slave modport of gray_counter_codec_if):
//        en/up/load/load_bin -> bin_out/gray_out/tc; gray_in/gray_in_valid -> dec_bin/dec_valid/step_err/err_sticky.
module gray_counter_codec #(
  parameter int WIDTH = 8,   // must be >= 2
  parameter bit WRAP  = 1'b1 // 1 = wrap at terminal values, 0 = saturate
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gray_counter_codec_if.slave  bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // counter state
  logic [WIDTH-1:0] bin_q, gray_q;
  logic             tc_q;
  logic [WIDTH-1:0] bin_nxt, gray_nxt;
  logic             tc_nxt;

  // decode state
  logic [WIDTH-1:0] dec_q, ref_q;
  logic             ref_valid_q, dec_valid_q, step_err_q, err_sticky_q;
  logic [WIDTH-1:0] dec_nxt, step_diff;
  logic             multi_bit, step_err_nxt;

  // Counter next state: load beats enable; tc marks a step attempted from a terminal value.
  always_comb begin
    bin_nxt = bin_q;
    tc_nxt  = 1'b0;
    if (bus.load) begin
      bin_nxt = bus.load_bin;
    end else if (bus.en) begin
      if (bus.up) begin
        if (bin_q == ALL_ONES) begin
          tc_nxt = 1'b1;
          if (WRAP) bin_nxt = '0;
        end else begin
          bin_nxt = bin_q + ONE;
        end
      end else begin
        if (bin_q == '0) begin
          tc_nxt = 1'b1;
          if (WRAP) bin_nxt = ALL_ONES;
        end else begin
          bin_nxt = bin_q - ONE;
        end
      end
    end
  end

  // Gray is taken from the next binary value so the two outputs can never disagree.
  assign gray_nxt = bin_nxt ^ (bin_nxt >> 1);

  // Each decoded bit is the XOR of all Gray bits at or above it.
  always_comb begin
    dec_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec_nxt[i] = ^(bus.gray_in >> i);
    end
  end

  // More than one bit changed <=> clearing the lowest set bit still leaves something.
  assign step_diff    = bus.gray_in ^ ref_q;
  assign multi_bit    = |(step_diff & (step_diff - ONE));
  assign step_err_nxt = bus.gray_in_valid & ref_valid_q & multi_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q        <= '0;
      gray_q       <= '0;
      tc_q         <= 1'b0;
      dec_q        <= '0;
      ref_q        <= '0;
      ref_valid_q  <= 1'b0;
      dec_valid_q  <= 1'b0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      bin_q       <= bin_nxt;
      gray_q      <= gray_nxt;
      tc_q        <= tc_nxt;
      dec_valid_q <= bus.gray_in_valid;
      step_err_q  <= step_err_nxt;
      if (bus.gray_in_valid) begin
        dec_q       <= dec_nxt;
        ref_q       <= bus.gray_in;
        ref_valid_q <= 1'b1;
      end
      if (step_err_nxt) err_sticky_q <= 1'b1;
    end
  end

  assign bus.bin_out    = bin_q;
  assign bus.gray_out   = gray_q;
  assign bus.tc         = tc_q;
  assign bus.dec_bin    = dec_q;
  assign bus.dec_valid  = dec_valid_q;
  assign bus.step_err   = step_err_q;
  assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_gray_counter_codec.sv
// Testbench for gray_counter_codec: three instances (4-bit wrap, 4-bit saturate, 8-bit decode focus).
// Expected values come from a behavioural model and are queued at drive time, popped after the clock edge.
module tb_gray_counter_codec;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gray_counter_codec_if #(.WIDTH(4)) if_w ();
  gray_counter_codec_if #(.WIDTH(4)) if_s ();
  gray_counter_codec_if #(.WIDTH(8)) if_d ();

  gray_counter_codec #(.WIDTH(4), .WRAP(1'b1)) dut_w (.clk(clk), .rst_n(rst_n), .bus(if_w.slave));
  gray_counter_codec #(.WIDTH(4), .WRAP(1'b0)) dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s.slave));
  gray_counter_codec #(.WIDTH(8), .WRAP(1'b1)) dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));

  typedef struct packed { logic [3:0] bin; logic [3:0] gray; logic tc; } cnt_exp_t;
  typedef struct packed { logic [7:0] dec; logic vld; logic err; logic sticky; } dec_exp_t;

  cnt_exp_t q_w[$];
  cnt_exp_t q_s[$];
  dec_exp_t q_d[$];

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int         mw_bin = 0;
  int         ms_bin = 0;
  logic [7:0] md_dec = '0;
  logic [7:0] md_ref = '0;
  bit         md_rvld = 1'b0;
  bit         md_sticky = 1'b0;

  // Behavioural counter, written with modulo arithmetic.
  function automatic void model_cnt(input bit wrap, input bit load, input bit en, input bit up,
                                    input int lb, inout int bin, output bit tc);
    tc = 1'b0;
    if (load) begin
      bin = lb;
    end else if (en) begin
      if (up && bin == 15) begin
        tc = 1'b1;
        if (wrap) bin = 0;
      end else if (!up && bin == 0) begin
        tc = 1'b1;
        if (wrap) bin = 15;
      end else begin
        bin = (bin + (up ? 1 : 15)) % 16;
      end
    end
  endfunction

  task automatic drive_cnt(input bit sat, input bit en, input bit up, input bit load, input int lb);
    bit       t;
    cnt_exp_t e;
    if (sat) begin
      if_s.en = en; if_s.up = up; if_s.load = load; if_s.load_bin = lb[3:0];
      model_cnt(1'b0, load, en, up, lb, ms_bin, t);
      e.bin = ms_bin[3:0];
    end else begin
      if_w.en = en; if_w.up = up; if_w.load = load; if_w.load_bin = lb[3:0];
      model_cnt(1'b1, load, en, up, lb, mw_bin, t);
      e.bin = mw_bin[3:0];
    end
    e.gray = e.bin ^ (e.bin >> 1);
    e.tc   = t;
    if (sat) q_s.push_back(e);
    else     q_w.push_back(e);
  endtask

  // Decode model: inverse found by searching the Gray table, adjacency by $countones.
  task automatic drive_dec(input bit vld, input logic [7:0] g);
    dec_exp_t e;
    int       b;
    if_d.gray_in = g;
    if_d.gray_in_valid = vld;
    e.err = 1'b0;
    if (vld) begin
      b = 0;
      for (int k = 0; k < 256; k++) if ((k ^ (k >> 1)) == int'(g)) b = k;
      e.err = md_rvld && ($countones(g ^ md_ref) > 1);
      md_dec = b[7:0];
      md_ref = g;
      md_rvld = 1'b1;
    end
    md_sticky = md_sticky | e.err;
    e.dec = md_dec;
    e.vld = vld;
    e.sticky = md_sticky;
    q_d.push_back(e);
  endtask

  task automatic idle_all();
    if_w.en = 0; if_w.up = 0; if_w.load = 0; if_w.load_bin = '0; if_w.gray_in = '0; if_w.gray_in_valid = 0;
    if_s.en = 0; if_s.up = 0; if_s.load = 0; if_s.load_bin = '0; if_s.gray_in = '0; if_s.gray_in_valid = 0;
    if_d.en = 0; if_d.up = 0; if_d.load = 0; if_d.load_bin = '0; if_d.gray_in = '0; if_d.gray_in_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({if_w.bin_out, if_w.gray_out, if_w.tc, if_s.bin_out, if_s.gray_out, if_s.tc} !== 18'd0) begin
        n_bad++;
        $display("FAIL reset_cnt cyc %0d: got w=%h/%h/%b s=%h/%h/%b, want all 0", i,
                 if_w.bin_out, if_w.gray_out, if_w.tc, if_s.bin_out, if_s.gray_out, if_s.tc);
      end
      n_cmp++;
      if ({if_d.dec_bin, if_d.dec_valid, if_d.step_err, if_d.err_sticky, if_d.bin_out, if_d.tc} !== 20'd0) begin
        n_bad++;
        $display("FAIL reset_dec cyc %0d: got dec=%h v=%b e=%b s=%b bin=%h tc=%b, want all 0", i,
                 if_d.dec_bin, if_d.dec_valid, if_d.step_err, if_d.err_sticky, if_d.bin_out, if_d.tc);
      end
    end
    rst_n = 1'b1;
    mw_bin = 0; ms_bin = 0;
  endtask

  task automatic test_increment_wrap();
    cnt_exp_t e;
    int       tc_seen = 0;
    for (int i = 0; i < 17; i++) begin
      drive_cnt(1'b0, 1'b1, 1'b1, 1'b0, 0);
      @(posedge clk); #1;
      e = q_w.pop_front();
      n_cmp++;
      if ({if_w.bin_out, if_w.gray_out, if_w.tc} !== {e.bin, e.gray, e.tc}) begin
        n_bad++;
        $display("FAIL inc_wrap cyc %0d: got bin=%0d gray=%h tc=%b, want bin=%0d gray=%h tc=%b", i,
                 if_w.bin_out, if_w.gray_out, if_w.tc, e.bin, e.gray, e.tc);
      end
      if (if_w.tc === 1'b1) begin
        tc_seen++;
        n_cmp++;
        if (if_w.bin_out !== 4'd0) begin
          n_bad++;
          $display("FAIL inc_tc_at_zero: got bin=%0d with tc, want 0", if_w.bin_out);
        end
      end
    end
    n_cmp++;
    if (tc_seen != 1) begin
      n_bad++;
      $display("FAIL inc_tc_count: got %0d tc pulses, want 1", tc_seen);
    end
    drive_cnt(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_decrement_saturate();
    cnt_exp_t e;
    drive_cnt(1'b1, 1'b0, 1'b0, 1'b1, 2);
    @(posedge clk); #1;
    e = q_s.pop_front();
    n_cmp++;
    if ({if_s.bin_out, if_s.gray_out, if_s.tc} !== {e.bin, e.gray, e.tc}) begin
      n_bad++;
      $display("FAIL sat_load: got bin=%0d gray=%h tc=%b, want bin=%0d gray=%h tc=%b",
               if_s.bin_out, if_s.gray_out, if_s.tc, e.bin, e.gray, e.tc);
    end
    for (int i = 0; i < 4; i++) begin
      drive_cnt(1'b1, 1'b1, 1'b0, 1'b0, 0);
      @(posedge clk); #1;
      e = q_s.pop_front();
      n_cmp++;
      if ({if_s.bin_out, if_s.gray_out, if_s.tc} !== {e.bin, e.gray, e.tc}) begin
        n_bad++;
        $display("FAIL sat_dec cyc %0d: got bin=%0d gray=%h tc=%b, want bin=%0d gray=%h tc=%b", i,
                 if_s.bin_out, if_s.gray_out, if_s.tc, e.bin, e.gray, e.tc);
      end
    end
    n_cmp++;
    if (if_s.gray_out !== 4'd0) begin
      n_bad++;
      $display("FAIL sat_final_gray: got %h, want 0", if_s.gray_out);
    end
    // saturate at the top as well
    drive_cnt(1'b1, 1'b0, 1'b0, 1'b1, 15);
    @(posedge clk); #1;
    void'(q_s.pop_front());
    for (int i = 0; i < 2; i++) begin
      drive_cnt(1'b1, 1'b1, 1'b1, 1'b0, 0);
      @(posedge clk); #1;
      e = q_s.pop_front();
      n_cmp++;
      if ({if_s.bin_out, if_s.gray_out, if_s.tc} !== {e.bin, e.gray, e.tc}) begin
        n_bad++;
        $display("FAIL sat_top cyc %0d: got bin=%0d gray=%h tc=%b, want bin=%0d gray=%h tc=%b", i,
                 if_s.bin_out, if_s.gray_out, if_s.tc, e.bin, e.gray, e.tc);
      end
    end
    drive_cnt(1'b1, 1'b0, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    e = q_s.pop_front();
    n_cmp++;
    if ({if_s.bin_out, if_s.tc} !== {e.bin, e.tc}) begin
      n_bad++;
      $display("FAIL sat_hold: got bin=%0d tc=%b, want bin=%0d tc=%b", if_s.bin_out, if_s.tc, e.bin, e.tc);
    end
  endtask

  task automatic test_load_priority();
    cnt_exp_t e;
    // (load, en, up, load_bin): set 5, load+en to 12, set 15, load+en at top, set 0, wrap down from 0
    int steps[6][4] = '{'{1, 0, 0, 5}, '{1, 1, 1, 12}, '{1, 0, 0, 15}, '{1, 1, 1, 3}, '{1, 0, 0, 0}, '{0, 1, 0, 0}};
    void'(q_w.pop_front()); // idle cycle left queued by the increment test
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      drive_cnt(1'b0, steps[i][1] != 0, steps[i][2] != 0, steps[i][0] != 0, steps[i][3]);
      @(posedge clk); #1;
      e = q_w.pop_front();
      n_cmp++;
      if ({if_w.bin_out, if_w.gray_out, if_w.tc} !== {e.bin, e.gray, e.tc}) begin
        n_bad++;
        $display("FAIL load_prio step %0d: got bin=%0d gray=%h tc=%b, want bin=%0d gray=%h tc=%b", i,
                 if_w.bin_out, if_w.gray_out, if_w.tc, e.bin, e.gray, e.tc);
      end
      if (i == 1) begin
        n_cmp++;
        if ({if_w.bin_out, if_w.gray_out, if_w.tc} !== {4'd12, 4'd10, 1'b0}) begin
          n_bad++;
          $display("FAIL load_12: got bin=%0d gray=%0d tc=%b, want 12/10/0", if_w.bin_out, if_w.gray_out, if_w.tc);
        end
      end
    end
    drive_cnt(1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    void'(q_w.pop_front());
  endtask

  task automatic test_decode();
    dec_exp_t   e;
    logic [7:0] seq [6] = '{8'h00, 8'h01, 8'h03, 8'h03, 8'h02, 8'h00};
    logic [7:0] want[5] = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd3};
    for (int i = 0; i < 6; i++) begin
      drive_dec(i < 5, seq[i]); // last entry is an idle cycle
      @(posedge clk); #1;
      e = q_d.pop_front();
      n_cmp++;
      if ({if_d.dec_bin, if_d.dec_valid, if_d.step_err, if_d.err_sticky} !== {e.dec, e.vld, e.err, e.sticky}) begin
        n_bad++;
        $display("FAIL decode cyc %0d: got dec=%h v=%b e=%b s=%b, want dec=%h v=%b e=%b s=%b", i,
                 if_d.dec_bin, if_d.dec_valid, if_d.step_err, if_d.err_sticky, e.dec, e.vld, e.err, e.sticky);
      end
      if (i < 5) begin
        n_cmp++;
        if (if_d.dec_bin !== want[i]) begin
          n_bad++;
          $display("FAIL decode_const cyc %0d: got %h, want %h", i, if_d.dec_bin, want[i]);
        end
      end
    end
  endtask

  task automatic test_step_error();
    dec_exp_t   e;
    logic [7:0] seq[3] = '{8'h07, 8'h06, 8'h00};
    bit         vld[3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive_dec(vld[i], seq[i]);
      @(posedge clk); #1;
      e = q_d.pop_front();
      n_cmp++;
      if ({if_d.dec_bin, if_d.dec_valid, if_d.step_err, if_d.err_sticky} !== {e.dec, e.vld, e.err, e.sticky}) begin
        n_bad++;
        $display("FAIL step_err cyc %0d: got dec=%h v=%b e=%b s=%b, want dec=%h v=%b e=%b s=%b", i,
                 if_d.dec_bin, if_d.dec_valid, if_d.step_err, if_d.err_sticky, e.dec, e.vld, e.err, e.sticky);
      end
      if (i == 0) begin
        n_cmp++;
        if ({if_d.dec_bin, if_d.step_err, if_d.err_sticky} !== {8'd5, 1'b1, 1'b1}) begin
          n_bad++;
          $display("FAIL step_err_const: got dec=%h e=%b s=%b, want 05/1/1", if_d.dec_bin, if_d.step_err, if_d.err_sticky);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    dec_exp_t e;
    // park the wrap counter at 15 and request a step into the reset edge: tc must be dropped
    drive_cnt(1'b0, 1'b0, 1'b0, 1'b1, 15);
    @(posedge clk); #1;
    void'(q_w.pop_front());
    if_w.en = 1; if_w.up = 1; if_w.load = 0;
    if_d.gray_in = 8'h55; if_d.gray_in_valid = 1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mw_bin = 0; ms_bin = 0;
    md_dec = '0; md_ref = '0; md_rvld = 0; md_sticky = 0;
    n_cmp++;
    if ({if_w.bin_out, if_w.tc} !== 5'd0) begin
      n_bad++;
      $display("FAIL midrst_cnt: got bin=%0d tc=%b, want 0/0", if_w.bin_out, if_w.tc);
    end
    n_cmp++;
    if ({if_d.dec_bin, if_d.dec_valid, if_d.step_err, if_d.err_sticky} !== 11'd0) begin
      n_bad++;
      $display("FAIL midrst_dec: got dec=%h v=%b e=%b s=%b, want all 0",
               if_d.dec_bin, if_d.dec_valid, if_d.step_err, if_d.err_sticky);
    end
    drive_cnt(1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 2; i++) begin
      drive_dec(1'b1, (i == 0) ? 8'hFF : 8'h00);
      @(posedge clk); #1;
      e = q_d.pop_front();
      n_cmp++;
      if ({if_d.dec_bin, if_d.dec_valid, if_d.step_err, if_d.err_sticky} !== {e.dec, e.vld, e.err, e.sticky}) begin
        n_bad++;
        $display("FAIL midrst_stream cyc %0d: got dec=%h v=%b e=%b s=%b, want dec=%h v=%b e=%b s=%b", i,
                 if_d.dec_bin, if_d.dec_valid, if_d.step_err, if_d.err_sticky, e.dec, e.vld, e.err, e.sticky);
      end
      if (i == 0) begin
        n_cmp++;
        if ({if_d.dec_bin, if_d.step_err} !== {8'hAA, 1'b0}) begin
          n_bad++;
          $display("FAIL midrst_ff: got dec=%h e=%b, want aa/0", if_d.dec_bin, if_d.step_err);
        end
      end
    end
    void'(q_w.pop_front());
  endtask

  // Counter and decoder running concurrently with random traffic.
  task automatic test_back_to_back();
    cnt_exp_t   ec;
    dec_exp_t   ed;
    logic [7:0] g = 8'h3C;
    for (int i = 0; i < 60; i++) begin
      drive_cnt(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));
      if ($urandom_range(0, 5) == 0) g = 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 3) != 0) g = g ^ (8'd1 << $urandom_range(0, 7));
      drive_dec($urandom_range(0, 3) != 0, g);
      @(posedge clk); #1;
      ec = q_s.pop_front();
      ed = q_d.pop_front();
      n_cmp++;
      if ({if_s.bin_out, if_s.gray_out, if_s.tc} !== {ec.bin, ec.gray, ec.tc}) begin
        n_bad++;
        $display("FAIL b2b_cnt cyc %0d: got bin=%0d gray=%h tc=%b, want bin=%0d gray=%h tc=%b", i,
                 if_s.bin_out, if_s.gray_out, if_s.tc, ec.bin, ec.gray, ec.tc);
      end
      n_cmp++;
      if ({if_d.dec_bin, if_d.dec_valid, if_d.step_err, if_d.err_sticky} !== {ed.dec, ed.vld, ed.err, ed.sticky}) begin
        n_bad++;
        $display("FAIL b2b_dec cyc %0d: got dec=%h v=%b e=%b s=%b, want dec=%h v=%b e=%b s=%b", i,
                 if_d.dec_bin, if_d.dec_valid, if_d.step_err, if_d.err_sticky, ed.dec, ed.vld, ed.err, ed.sticky);
      end
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_increment_wrap();
    test_decrement_saturate();
    test_load_priority();
    test_decode();
    test_step_error();
    test_reset_midstream();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
